bullet_ctrl: RTL and testbench

- Generates and animates the player's bullet, the position source that every obstacle block samples for collision.
- Launches on a fire request from the ship position, climbs a fixed number of pixels per frame and parks once it leaves the top edge or an obstacle reports a hit.
- Draws itself into the pixel stream and keeps a saturating hit counter for the score logic.

---
 rtl/game_pkg.sv | 18 +
 rtl/bullet_ctrl_if.sv | 23 ++
 rtl/edge_detect.sv | 23 ++
 rtl/bullet_ctrl.sv | 125 ++++++++++++
 tb/tb_bullet_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared screen geometry, bullet FSM encoding and colour constants for the
// game video pipeline.
package game_pkg;

  localparam int MAX_X        = 640;
  localparam int MAX_Y        = 480;
  localparam int FRAME_TICK_Y = 481;

  localparam logic [2:0] BULLET_RGB = 3'b110;
  localparam logic [2:0] BLACK      = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } bullet_state_t;

endpackage

// File: rtl/bullet_ctrl_if.sv
// Pixel-stream link between the sync generator / mixer and the bullet:
// scan position in, bullet position and colour contribution out.
interface bullet_ctrl_if;

  logic        video_on;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic [10:0] bull_x;
  logic [10:0] bull_y;
  logic        bull_on;
  logic [2:0]  rgb;

  modport master (
    output video_on, pix_x, pix_y,
    input  bull_x, bull_y, bull_on, rgb
  );

  modport slave (
    input  video_on, pix_x, pix_y,
    output bull_x, bull_y, bull_on, rgb
  );

endinterface

// File: rtl/edge_detect.sv
// Per-bit rise or fall detector with a configurable reset value, so that the
// first cycle after reset produces no spurious edge.
module edge_detect #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               FALL    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_q <= RST_VAL;
    else        d_q <= d;
  end

  assign pulse = FALL ? (d_q & ~d) : (d & ~d_q);

endmodule

// File: rtl/bullet_ctrl.sv
// Player bullet: launches from the ship on a fire edge, climbs once per frame,
// parks on a hit or when leaving the top edge, and renders into the pixel stream.
module bullet_ctrl
  import game_pkg::*;
#(
  parameter int BULLET_V = 4,
  parameter int BULLET_W = 2,
  parameter int BULLET_H = 6,
  parameter int COOLDOWN = 8,
  parameter int N_OBS    = 4
) (
  input  logic             clk,
  input  logic             reset,
  bullet_ctrl_if.slave     vid,
  input  logic             fire,
  input  logic [10:0]      ship_x,
  input  logic [10:0]      ship_y,
  input  logic [N_OBS-1:0] obs_state,
  output logic             active,
  output logic [7:0]       hit_count
);

  localparam int            CW        = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN);
  localparam logic [10:0]   V11       = 11'(BULLET_V);
  localparam logic [10:0]   H11       = 11'(BULLET_H);
  localparam logic [10:0]   W_M1      = 11'(BULLET_W - 1);
  localparam logic [10:0]   H_M1      = 11'(BULLET_H - 1);
  localparam bullet_state_t AFTER_FLY = (COOLDOWN == 0) ? IDLE : COOL;

  bullet_state_t    state, state_next;
  logic [10:0]      pos_x, pos_y;
  logic [CW-1:0]    cool_cnt;
  logic             fire_edge;
  logic [N_OBS-1:0] obs_fall;
  logic             hit_edge;
  logic             frame_tick;
  logic             leave_fly;

  edge_detect #(.WIDTH(1), .RST_VAL(1'b0), .FALL(1'b0)) u_fire_edge (
    .clk   (clk),
    .reset (reset),
    .d     (fire),
    .pulse (fire_edge)
  );

  edge_detect #(.WIDTH(N_OBS), .RST_VAL({N_OBS{1'b1}}), .FALL(1'b1)) u_obs_edge (
    .clk   (clk),
    .reset (reset),
    .d     (obs_state),
    .pulse (obs_fall)
  );

  assign hit_edge   = |obs_fall;
  assign frame_tick = (vid.pix_y == 11'(FRAME_TICK_Y)) && (vid.pix_x == 11'd0);
  // A hit wins over a frame tick, so a coincident tick never moves the bullet.
  assign leave_fly  = hit_edge || (frame_tick && (pos_y < V11));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fire_edge) state_next = FLY;
      FLY:     if (leave_fly) state_next = AFTER_FLY;
      COOL:    if (cool_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_x     <= '0;
      pos_y     <= '0;
      cool_cnt  <= '0;
      hit_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire_edge) begin
            pos_x <= ship_x;
            pos_y <= (ship_y < H11) ? 11'd0 : ship_y - H11;
          end else begin
            pos_x <= '0;
            pos_y <= '0;
          end
        end
        FLY: begin
          if (leave_fly) begin
            pos_x    <= '0;
            pos_y    <= '0;
            cool_cnt <= COOL_LOAD;
            if (hit_edge && (hit_count != 8'hFF)) hit_count <= hit_count + 8'd1;
          end else if (frame_tick) begin
            pos_y <= pos_y - V11;
          end
        end
        COOL: begin
          pos_x <= '0;
          pos_y <= '0;
          if (frame_tick && (cool_cnt != '0)) cool_cnt <= cool_cnt - CW'(1);
        end
        default: begin
          pos_x <= '0;
          pos_y <= '0;
        end
      endcase
    end
  end

  always_comb begin
    active      = (state == FLY);
    vid.bull_on = active
                  && (vid.pix_x >= pos_x) && (vid.pix_x <= pos_x + W_M1)
                  && (vid.pix_y >= pos_y) && (vid.pix_y <= pos_y + H_M1);
    vid.rgb     = (vid.video_on && vid.bull_on) ? BULLET_RGB : BLACK;
  end

  assign vid.bull_x = pos_x;
  assign vid.bull_y = pos_y;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Scenario bench for bullet_ctrl: expectations are queued as stimulus is
// applied and popped against the outputs once the DUT has responded.
module tb_bullet_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fire = 1'b0;
  logic [10:0] ship_x = '0;
  logic [10:0] ship_y = '0;
  logic [3:0]  obs_state = 4'hF;
  logic        active;
  logic [7:0]  hit_count;

  bullet_ctrl_if vif();

  bullet_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .vid       (vif.slave),
    .fire      (fire),
    .ship_x    (ship_x),
    .ship_y    (ship_y),
    .obs_state (obs_state),
    .active    (active),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned val;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_hits = 0;

  task automatic push(input string n, input int unsigned v);
    exp_q.push_back('{n, v});
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vif.pix_x = 11'd0;
    vif.pix_y = 11'd481;
    step();
    vif.pix_y = 11'd0;
  endtask

  task automatic pulse_fire();
    fire = 1'b1;
    step();
    fire = 1'b0;
  endtask

  task automatic cooldown();
    repeat (8) frame();
    step();
  endtask

  task automatic finish_shot();
    int n = 0;
    while (active && n < 300) begin
      frame();
      n++;
    end
    checks++;
    if (active !== 1'b0) begin
      failures++;
      $display("FAIL fly_out_timeout active=%0b expected=0", active);
    end
    cooldown();
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    push("rst_active", 0); push("rst_x", 0); push("rst_y", 0);
    push("rst_hits", 0); push("rst_bull_on", 0);
    step(2);
    e = exp_q.pop_front(); checks++;
    if (32'(active) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, active, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_x) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_x, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_y) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_y, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(hit_count) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, hit_count, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_on) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_on, e.val); end
    reset = 1'b1;
    step(2);
  endtask

  task automatic test_launch();
    exp_t e;
    ship_x = 11'd300; ship_y = 11'd440;
    push("launch_active", 1); push("launch_x", 300); push("launch_y", 434);
    pulse_fire();
    e = exp_q.pop_front(); checks++;
    if (32'(active) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, active, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_x) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_x, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_y) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_y, e.val); end
    push("climb_y", 430);
    frame();
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_y) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_y, e.val); end
    finish_shot();
    push("flyout_hits", 32'(exp_hits));
    e = exp_q.pop_front(); checks++;
    if (32'(hit_count) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, hit_count, e.val); end
  endtask

  task automatic test_hold_fire();
    exp_t e;
    ship_x = 11'd300; ship_y = 11'd440;
    fire = 1'b1;
    push("hold_launch", 1);
    step();
    e = exp_q.pop_front(); checks++;
    if (32'(active) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, active, e.val); end
    push("hold_active", 1); push("hold_y", 414);
    repeat (5) frame();
    e = exp_q.pop_front(); checks++;
    if (32'(active) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, active, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_y) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_y, e.val); end
    obs_state[0] = 1'b0;
    exp_hits++;
    push("hold_hit", 32'(exp_hits));
    step();
    obs_state = 4'hF;
    e = exp_q.pop_front(); checks++;
    if (32'(hit_count) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, hit_count, e.val); end
    cooldown();
    push("hold_no_relaunch", 0);
    step(2);
    e = exp_q.pop_front(); checks++;
    if (32'(active) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, active, e.val); end
    fire = 1'b0;
    step();
    push("hold_new_edge", 1);
    pulse_fire();
    e = exp_q.pop_front(); checks++;
    if (32'(active) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, active, e.val); end
    finish_shot();
  endtask

  task automatic test_top_edge();
    exp_t e;
    ship_x = 11'd300; ship_y = 11'd10;
    push("top_y0", 4);
    pulse_fire();
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_y) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_y, e.val); end
    push("top_y1", 0); push("top_active1", 1);
    frame();
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_y) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_y, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(active) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, active, e.val); end
    push("top_exit_active", 0); push("top_exit_y", 0); push("top_exit_hits", 32'(exp_hits));
    frame();
    e = exp_q.pop_front(); checks++;
    if (32'(active) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, active, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_y) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_y, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(hit_count) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, hit_count, e.val); end
    repeat (7) frame();
    step();
    push("cool_fire_ignored", 0);
    pulse_fire();
    e = exp_q.pop_front(); checks++;
    if (32'(active) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, active, e.val); end
    frame();
    step();
    push("cool_done_fire", 1);
    pulse_fire();
    e = exp_q.pop_front(); checks++;
    if (32'(active) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, active, e.val); end
    finish_shot();
  endtask

  task automatic test_hit();
    exp_t e;
    ship_x = 11'd300; ship_y = 11'd440;
    pulse_fire();
    frame();
    obs_state[2] = 1'b0;
    exp_hits++;
    push("hit_active", 0); push("hit_count", 32'(exp_hits)); push("hit_x", 0); push("hit_y", 0);
    step();
    e = exp_q.pop_front(); checks++;
    if (32'(active) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, active, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(hit_count) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, hit_count, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_x) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_x, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_y) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_y, e.val); end
    obs_state[1] = 1'b0;
    push("hit_in_cool", 32'(exp_hits));
    step(2);
    e = exp_q.pop_front(); checks++;
    if (32'(hit_count) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, hit_count, e.val); end
    obs_state = 4'hF;
    cooldown();
  endtask

  task automatic test_coincident();
    exp_t e;
    ship_x = 11'd300; ship_y = 11'd440;
    pulse_fire();
    obs_state[3] = 1'b0;
    vif.pix_x = 11'd0;
    vif.pix_y = 11'd481;
    exp_hits++;
    push("coin_active", 0); push("coin_y", 0); push("coin_hits", 32'(exp_hits));
    step();
    vif.pix_y = 11'd0;
    obs_state = 4'hF;
    e = exp_q.pop_front(); checks++;
    if (32'(active) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, active, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_y) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_y, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(hit_count) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, hit_count, e.val); end
    push("coin_once", 32'(exp_hits));
    step(2);
    e = exp_q.pop_front(); checks++;
    if (32'(hit_count) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, hit_count, e.val); end
    cooldown();
  endtask

  task automatic test_saturate();
    exp_t e;
    ship_x = 11'd50; ship_y = 11'd300;
    for (int i = 0; i < 260; i++) begin
      pulse_fire();
      obs_state[0] = 1'b0;
      step();
      obs_state = 4'hF;
      if (exp_hits < 255) exp_hits++;
      cooldown();
    end
    push("sat_hits", 32'(exp_hits));
    e = exp_q.pop_front(); checks++;
    if (32'(hit_count) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, hit_count, e.val); end
  endtask

  task automatic test_render();
    exp_t e;
    ship_x = 11'd100; ship_y = 11'd206;
    pulse_fire();
    vif.video_on = 1'b1;
    for (int y = 199; y <= 207; y++) begin
      for (int x = 99; x <= 102; x++) begin
        push($sformatf("rgb_%0d_%0d", x, y),
             (x >= 100 && x <= 101 && y >= 200 && y <= 205) ? 6 : 0);
        vif.pix_x = 11'(x);
        vif.pix_y = 11'(y);
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(vif.rgb) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.rgb, e.val); end
      end
    end
    vif.video_on = 1'b0;
    vif.pix_x = 11'd100;
    vif.pix_y = 11'd200;
    push("blank_rgb", 0); push("blank_bull_on", 1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(vif.rgb) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.rgb, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_on) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_on, e.val); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    vif.video_on = 1'b1;
    reset = 1'b0;
    exp_hits = 0;
    push("mid_active", 0); push("mid_x", 0); push("mid_y", 0); push("mid_rgb", 0); push("mid_hits", 0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(active) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, active, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_x) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_x, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(vif.bull_y) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.bull_y, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(vif.rgb) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, vif.rgb, e.val); end
    e = exp_q.pop_front(); checks++;
    if (32'(hit_count) !== e.val) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, hit_count, e.val); end
    step();
    reset = 1'b1;
    step(2);
  endtask

  initial begin
    vif.video_on = 1'b0;
    vif.pix_x = 11'd0;
    vif.pix_y = 11'd0;
    test_reset();
    test_launch();
    test_hold_fire();
    test_top_edge();
    test_hit();
    test_coincident();
    test_saturate();
    test_render();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
